mem_bus_ctrl: RTL
=================

Name: mem_bus_ctrl

Overview:
- Parametrised Avalon-MM master access unit between the CPU core and memory; replaces the hard-wired bus hookup in the CPU top level.
- Accepts one load/store request at a time from the core and issues a single Avalon read or write.
- Stalls on waitrequest, with a bounded timeout.
- Generates byteenable and lane-shifts writedata for sub-word stores; extracts and sign/zero-extends sub-word load data.

Parameters:
- DATA_W, 32, bus and register data width; legal values are 32 and 64.
- ADDR_W, 32, byte-address width.
- TIMEOUT_CYCLES, 255, maximum waitrequest cycles before a request is aborted with an error; 0 disables the timeout.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n_i  input  1  reset, synchronous, active-low.
- req_valid_i  input  1  core request valid.
- req_ready_o  output  1  unit can accept a request.
- req_write_i  input  1  1 = store, 0 = load.
- req_size_i  input  2  mem_size_t: BYTE=0, HALF=1, WORD=2, DWORD=3 (DWORD only when DATA_W=64).
- req_signed_i  input  1  sign-extend load result.
- req_addr_i  input  ADDR_W  byte address.
- req_wdata_i  input  DATA_W  store data, right-justified.
- resp_valid_o  output  1  one-cycle completion pulse.
- resp_rdata_o  output  DATA_W  formatted load data; 0 for stores.
- resp_err_o  output  1  timeout or misalignment; qualified by resp_valid_o.
- busy_o  output  1  request in flight.
- address_o  output  ADDR_W  bus word address; low log2(DATA_W/8) bits are 0.
- read_o  output  1  Avalon read.
- write_o  output  1  Avalon write.
- waitrequest_i  input  1  Avalon slave stall.
- writedata_o  output  DATA_W  lane-shifted store data.
- byteenable_o  output  DATA_W/8  active byte lanes.
- readdata_i  input  DATA_W  Avalon read data; valid in the cycle read_o=1 and waitrequest_i=0.

Behaviour:
- Reset: all outputs are registered or decoded from registered state. While reset_n_i=0, at each edge:
  - state=IDLE, and read_o, write_o, resp_valid_o, resp_err_o, busy_o = 0.
  - address_o, writedata_o, byteenable_o, resp_rdata_o = 0.
  - Timeout counter = 0.
  - req_ready_o=0 during reset; it is 1 in IDLE afterwards.
- Reset asserted mid-transaction: the transaction is abandoned and read_o/write_o are low after that edge.
- FSM states (mem_state_t): IDLE, BUS, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i=1, latch the request; the next state is BUS.
- BUS:
  - busy_o=1; read_o or write_o is held high.
  - address_o, byteenable_o and writedata_o are stable for the whole state.
  - While waitrequest_i=1: the counter increments and the unit stays in BUS.
  - When waitrequest_i=0: the transfer completes, readdata_i is captured and formatted, and the next state is RESP.
  - If TIMEOUT_CYCLES!=0, the counter equals TIMEOUT_CYCLES and waitrequest_i is still 1: read_o/write_o are dropped and the next state is RESP with err=1.
- RESP:
  - resp_valid_o=1 for exactly one cycle; the next state is IDLE.
  - req_ready_o=0, so there are no back-to-back accepts. Minimum spacing between requests is 3 cycles.
- Latency: request accepted at edge N; bus cycle begins N; resp_valid_o high in cycle N+2 with zero wait states; each wait cycle adds 1.
- Lane select: lane = req_addr_i[log2(DATA_W/8)-1:0], aligned down to the size: HALF clears bit 0, WORD clears bits 1:0, DWORD clears all.
- byteenable_o: BYTE = 1<<lane, HALF = 2'b11<<lane, WORD = 4'hF<<lane, DWORD = all ones. Computed identically for loads and stores.
- writedata_o = req_wdata_i << (8*lane); unused lanes are don't-care but driven 0.
- Load formatting: shift readdata_i right by 8*lane, mask to the access size, then:
  - req_signed_i=1: sign-extend from the access MSB to DATA_W.
  - Otherwise: zero-extend.
- Stores return resp_rdata_o=0.
- req_size_i=DWORD with DATA_W=32 is treated as WORD.
- Inputs are ignored outside IDLE.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- When defined: a request whose address is not a multiple of its size issues no bus cycle. The unit goes IDLE→RESP with resp_err_o=1 and resp_rdata_o=0, so resp_valid_o is high in cycle N+1.
- When undefined: low address bits are silently force-aligned as described under lane select, and no error is raised.

Decomposition:
- Package codes gains:
  - mem_size_t enum (BYTE, HALF, WORD, DWORD).
  - mem_state_t enum (IDLE, BUS, RESP).
  - Localparam MEM_LANE_W computed from DATA_W.
- One combinational sub-module, mem_lane_align. It holds the lane alignment, byteenable/writedata generation and the read extract/extend. It is instantiated once; the FSM and counter stay in mem_bus_ctrl.

Test Plan:
- Word load, zero wait states: addr 0x1004, size WORD, readdata 0xDEADBEEF → read_o high 1 cycle, address_o=0x1004, byteenable 4'hF; resp_valid in cycle N+2; rdata 0xDEADBEEF, err=0.
- Signed byte load at addr 0x2003, readdata 0x80112233 → byteenable 4'b1000, rdata 0xFFFFFF80. Same access unsigned → 0x00000080.
- Half store at addr 0x3002, wdata 0x0000ABCD, waitrequest high 3 cycles → write_o high 4 cycles with address_o=0x3000, writedata 0xABCD0000, byteenable 4'b1100 stable throughout; resp_valid 1 cycle after waitrequest falls.
- Timeout with TIMEOUT_CYCLES=4, waitrequest stuck at 1 → read_o drops after 4 wait cycles; resp_valid=1 with err=1; next request accepted normally.
- Misaligned WORD load at addr 0x1002:
  - MEM_ALIGN_CHECK_EN defined → no read_o; resp_valid in cycle N+1 with err=1.
  - Undefined → address_o=0x1000, byteenable 4'hF, err=0.
- reset_n_i low during BUS with waitrequest=1 → read_o=0 and req_ready_o=0 after the edge; req_ready_o=1 after release; no resp_valid pulse.

Source files
------------

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and width helpers for the mem_bus_ctrl Avalon-MM access unit.
package mem_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        BYTE  = 2'd0,
        HALF  = 2'd1,
        WORD  = 2'd2,
        DWORD = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    function automatic int mem_lane_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    localparam int MEM_DATA_W = 32;
    localparam int MEM_LANE_W = mem_lane_w(MEM_DATA_W);

endpackage

// File: rtl/mem_bus_ctrl_lane_align.sv
// Byte-lane steering: byteenable and writedata generation, load extract and extend.
module mem_lane_align
    import mem_bus_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = mem_lane_w(DATA_W)
) (
    input  logic [1:0]          size,
    input  logic [LANE_W-1:0]   addr_lo,
    input  logic                is_signed,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]   rdata,
    output logic [DATA_W/8-1:0] byteenable,
    output logic [DATA_W-1:0]   writedata,
    output logic [DATA_W-1:0]   rdata_fmt,
    output logic                misaligned
);

    localparam int BE_W = DATA_W / 8;

    mem_size_t           size_eff;
    logic [LANE_W-1:0]   low_mask;
    logic [LANE_W-1:0]   lane;
    logic [LANE_W+2:0]   bit_shift;
    logic [BE_W-1:0]     be_base;
    logic [DATA_W-1:0]   size_mask;
    logic [DATA_W-1:0]   shifted;
    logic                sign_bit;

    always_comb begin
        size_eff = mem_size_t'(size);
        // A 32-bit bus has no DWORD lane pattern; fold it onto WORD.
        if (DATA_W == 32 && size_eff == DWORD) begin
            size_eff = WORD;
        end

        low_mask  = '0;
        be_base   = '0;
        size_mask = '0;
        case (size_eff)
            BYTE: begin
                low_mask  = '0;
                be_base   = BE_W'(1);
                size_mask = DATA_W'(32'h0000_00FF);
            end
            HALF: begin
                low_mask  = LANE_W'(1);
                be_base   = BE_W'(3);
                size_mask = DATA_W'(32'h0000_FFFF);
            end
            WORD: begin
                low_mask  = LANE_W'(3);
                be_base   = BE_W'(15);
                size_mask = DATA_W'(32'hFFFF_FFFF);
            end
            default: begin
                low_mask  = '1;
                be_base   = '1;
                size_mask = '1;
            end
        endcase

        lane       = addr_lo & ~low_mask;
        misaligned = |(addr_lo & low_mask);
        bit_shift  = {lane, 3'b000};

        byteenable = be_base << lane;
        writedata  = (wdata & size_mask) << bit_shift;
        shifted    = (rdata >> bit_shift) & size_mask;

        case (size_eff)
            BYTE:    sign_bit = shifted[7];
            HALF:    sign_bit = shifted[15];
            WORD:    sign_bit = shifted[31];
            default: sign_bit = 1'b0;
        endcase

        rdata_fmt = (is_signed && sign_bit) ? (shifted | ~size_mask) : shifted;
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Avalon-MM master access unit: one load/store at a time with waitrequest timeout.
// Build option MEM_ALIGN_CHECK_EN: misaligned requests skip the bus and return an error.
//
// state | meaning
// IDLE  | ready for a core request
// BUS   | Avalon read/write asserted, waiting for waitrequest to drop or timeout
// RESP  | one-cycle response pulse back to the core
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset_n_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_write_i,
    input  logic [1:0]          req_size_i,
    input  logic                req_signed_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    output logic                resp_valid_o,
    output logic [DATA_W-1:0]   resp_rdata_o,
    output logic                resp_err_o,
    output logic                busy_o,
    output logic [ADDR_W-1:0]   address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                waitrequest_i,
    output logic [DATA_W-1:0]   writedata_o,
    output logic [DATA_W/8-1:0] byteenable_o,
    input  logic [DATA_W-1:0]   readdata_i
);

    localparam int LANE_W = mem_lane_w(DATA_W);
    localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

`ifdef MEM_ALIGN_CHECK_EN
    localparam logic ALIGN_CHECK = 1'b1;
`else
    localparam logic ALIGN_CHECK = 1'b0;
`endif

    mem_state_t          state;
    logic [CNT_W-1:0]    wait_cnt;
    logic                lat_write;
    logic [1:0]          lat_size;
    logic                lat_signed;
    logic [LANE_W-1:0]   lat_addr_lo;

    logic [1:0]          al_size;
    logic [LANE_W-1:0]   al_addr_lo;
    logic                al_signed;
    logic [DATA_W/8-1:0] al_byteenable;
    logic [DATA_W-1:0]   al_writedata;
    logic [DATA_W-1:0]   al_rdata_fmt;
    logic                al_misaligned;

    // Lane logic sees the live request while idle and the latched one during the bus cycle.
    assign al_size    = (state == IDLE) ? req_size_i              : lat_size;
    assign al_addr_lo = (state == IDLE) ? req_addr_i[LANE_W-1:0]  : lat_addr_lo;
    assign al_signed  = (state == IDLE) ? req_signed_i            : lat_signed;

    mem_lane_align #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W)
    ) u_lane_align (
        .size       (al_size),
        .addr_lo    (al_addr_lo),
        .is_signed  (al_signed),
        .wdata      (req_wdata_i),
        .rdata      (readdata_i),
        .byteenable (al_byteenable),
        .writedata  (al_writedata),
        .rdata_fmt  (al_rdata_fmt),
        .misaligned (al_misaligned)
    );

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            lat_write    <= 1'b0;
            lat_size     <= 2'd0;
            lat_signed   <= 1'b0;
            lat_addr_lo  <= '0;
            req_ready_o  <= 1'b0;
            resp_valid_o <= 1'b0;
            resp_err_o   <= 1'b0;
            resp_rdata_o <= '0;
            busy_o       <= 1'b0;
            read_o       <= 1'b0;
            write_o      <= 1'b0;
            address_o    <= '0;
            writedata_o  <= '0;
            byteenable_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    resp_valid_o <= 1'b0;
                    resp_err_o   <= 1'b0;
                    if (req_ready_o && req_valid_i) begin
                        req_ready_o <= 1'b0;
                        lat_write   <= req_write_i;
                        lat_size    <= req_size_i;
                        lat_signed  <= req_signed_i;
                        lat_addr_lo <= req_addr_i[LANE_W-1:0];
                        if (ALIGN_CHECK && al_misaligned) begin
                            state        <= RESP;
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                            resp_rdata_o <= '0;
                        end else begin
                            state        <= BUS;
                            wait_cnt     <= '0;
                            busy_o       <= 1'b1;
                            read_o       <= ~req_write_i;
                            write_o      <= req_write_i;
                            address_o    <= {req_addr_i[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                            byteenable_o <= al_byteenable;
                            writedata_o  <= al_writedata;
                        end
                    end else begin
                        req_ready_o <= 1'b1;
                    end
                end

                BUS: begin
                    if (!waitrequest_i) begin
                        state        <= RESP;
                        busy_o       <= 1'b0;
                        read_o       <= 1'b0;
                        write_o      <= 1'b0;
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b0;
                        resp_rdata_o <= lat_write ? '0 : al_rdata_fmt;
                    end else if (TIMEOUT_CYCLES != 0 && wait_cnt == CNT_LIMIT) begin
                        state        <= RESP;
                        busy_o       <= 1'b0;
                        read_o       <= 1'b0;
                        write_o      <= 1'b0;
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b1;
                        resp_rdata_o <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                RESP: begin
                    state        <= IDLE;
                    resp_valid_o <= 1'b0;
                    resp_err_o   <= 1'b0;
                    req_ready_o  <= 1'b1;
                end

                default: begin
                    state       <= IDLE;
                    busy_o      <= 1'b0;
                    read_o      <= 1'b0;
                    write_o     <= 1'b0;
                    req_ready_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
